axis_step_driver: RTL and testbench

- Downstream of the point-by-point interpolator. Consumes its one-cycle X_acc/X_dec/Y_acc/Y_dec motion pulses and produces STEP/DIR motor-driver signals per axis.
- Enforces direction setup time and minimum step high/low widths.
- Tracks signed absolute position per axis.
- Reports when a finished interpolation has fully drained to the motors.

---
 rtl/axis_step_driver.sv | 124 ++++++++++++
 tb/tb_axis_step_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_step_driver.sv
// axis_step_driver: turns interpolator motion pulses into STEP/DIR with setup and width timing,
// tracks signed position per axis and flags when a finished interpolation has drained.
module axis_step_axis #(
    parameter int STEP_HI   = 2,
    parameter int STEP_LO   = 2,
    parameter int DIR_SETUP = 1,
    parameter int POS_W     = 16,
    parameter int CNT_W     = 8
) (
    input  logic             pulse_clk,
    input  logic             sys_rst_l,
    input  logic             acc,
    input  logic             dec,
    input  logic             pos_clr,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;
    localparam logic [CNT_W-1:0] HI_N = CNT_W'(STEP_HI - 1);
    localparam logic [CNT_W-1:0] LO_N = CNT_W'(STEP_LO - 1);
    localparam logic [CNT_W-1:0] SU_N = CNT_W'(DIR_SETUP - 1);
    localparam logic [POS_W-1:0] ONE  = 1;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_v, pend_d;
    logic             req, done_cnt, serve, take_dir, consume, store, store_ok, enter_high;
    assign req        = acc ^ dec;
    assign done_cnt   = cnt == '0;
    assign serve      = (state == S_IDLE && (req || pend_v)) || (state == S_LOW && done_cnt && pend_v);
    assign take_dir   = pend_v ? pend_d : dec;
    assign consume    = serve && pend_v;
    // a request not taken straight from idle competes for the single pending slot
    assign store      = req && !(state == S_IDLE && !pend_v);
    assign store_ok   = store && (!pend_v || consume);
    assign err        = (acc && dec) || (store && !store_ok);
    assign enter_high = (serve && take_dir == dir) || (state == S_SETUP && done_cnt);
    assign busy       = state != S_IDLE || pend_v;
    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state  <= S_IDLE;
            cnt    <= '0;
            step   <= 1'b0;
            dir    <= 1'b0;
            pos    <= '0;
            pend_v <= 1'b0;
            pend_d <= 1'b0;
        end else begin
            if (store_ok) begin
                pend_v <= 1'b1;
                pend_d <= dec;
            end else if (consume) begin
                pend_v <= 1'b0;
            end
            pos <= pos_clr ? '0 : enter_high ? (dir ? pos - ONE : pos + ONE) : pos;
            if (enter_high) begin
                state <= S_HIGH;
                step  <= 1'b1;
                cnt   <= HI_N;
            end else if (serve) begin
                state <= S_SETUP;
                dir   <= take_dir;
                cnt   <= SU_N;
            end else if (!done_cnt) begin
                cnt <= cnt - 1'b1;
            end else if (state == S_HIGH) begin
                state <= S_LOW;
                step  <= 1'b0;
                cnt   <= LO_N;
            end else if (state == S_LOW) begin
                state <= S_IDLE;
            end
        end
    end
endmodule

module axis_step_driver #(
    parameter int STEP_HI   = 2,
    parameter int STEP_LO   = 2,
    parameter int DIR_SETUP = 1,
    parameter int POS_W     = 16,
    parameter int CNT_W     = 8
) (
    input  logic             pulse_clk,
    input  logic             sys_rst_l,
    input  logic             X_acc,
    input  logic             X_dec,
    input  logic             Y_acc,
    input  logic             Y_dec,
    input  logic             draw_overH,
    input  logic             pos_clr,
    output logic             X_step,
    output logic             X_dir,
    output logic             Y_step,
    output logic             Y_dir,
    output logic [POS_W-1:0] X_pos,
    output logic [POS_W-1:0] Y_pos,
    output logic             busyH,
    output logic             motion_doneH,
    output logic             step_errH
);
    logic x_busy, y_busy, x_err, y_err, armed;
    axis_step_axis #(.STEP_HI(STEP_HI), .STEP_LO(STEP_LO), .DIR_SETUP(DIR_SETUP), .POS_W(POS_W), .CNT_W(CNT_W)) u_x (
        .pulse_clk(pulse_clk), .sys_rst_l(sys_rst_l), .acc(X_acc), .dec(X_dec), .pos_clr(pos_clr),
        .step(X_step), .dir(X_dir), .pos(X_pos), .busy(x_busy), .err(x_err)
    );
    axis_step_axis #(.STEP_HI(STEP_HI), .STEP_LO(STEP_LO), .DIR_SETUP(DIR_SETUP), .POS_W(POS_W), .CNT_W(CNT_W)) u_y (
        .pulse_clk(pulse_clk), .sys_rst_l(sys_rst_l), .acc(Y_acc), .dec(Y_dec), .pos_clr(pos_clr),
        .step(Y_step), .dir(Y_dir), .pos(Y_pos), .busy(y_busy), .err(y_err)
    );
    assign busyH        = x_busy || y_busy;
    assign motion_doneH = armed && !busyH;
    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            armed     <= 1'b0;
            step_errH <= 1'b0;
        end else begin
            armed     <= draw_overH || (armed && busyH);
            step_errH <= step_errH || x_err || y_err;
        end
    end
endmodule

// File: tb/tb_axis_step_driver.sv
// tb_axis_step_driver: directed stimulus checked cycle by cycle against a move-schedule model,
// plus hand-computed expectations at key points and a narrow-position instance for wrap.
module tb_axis_step_driver;
    localparam int HI = 2;
    localparam int LO = 2;
    localparam int DS = 1;
    logic pulse_clk = 1'b0, sys_rst_l = 1'b0;
    logic X_acc = 1'b0, X_dec = 1'b0, Y_acc = 1'b0, Y_dec = 1'b0, draw_overH = 1'b0, pos_clr = 1'b0;
    logic X_step, X_dir, Y_step, Y_dir, busyH, motion_doneH, step_errH;
    logic [15:0] X_pos, Y_pos;
    logic w_acc = 1'b0;
    logic w_xs, w_xd, w_ys, w_yd, w_busy, w_done, w_err;
    logic [3:0] w_xp, w_yp;
    int checks = 0, errors = 0, done_seen = 0;

    axis_step_driver dut (
        .pulse_clk(pulse_clk), .sys_rst_l(sys_rst_l), .X_acc(X_acc), .X_dec(X_dec), .Y_acc(Y_acc), .Y_dec(Y_dec),
        .draw_overH(draw_overH), .pos_clr(pos_clr), .X_step(X_step), .X_dir(X_dir), .Y_step(Y_step), .Y_dir(Y_dir),
        .X_pos(X_pos), .Y_pos(Y_pos), .busyH(busyH), .motion_doneH(motion_doneH), .step_errH(step_errH)
    );
    axis_step_driver #(.POS_W(4)) dut_w (
        .pulse_clk(pulse_clk), .sys_rst_l(sys_rst_l), .X_acc(w_acc), .X_dec(1'b0), .Y_acc(1'b0), .Y_dec(1'b0),
        .draw_overH(1'b0), .pos_clr(1'b0), .X_step(w_xs), .X_dir(w_xd), .Y_step(w_ys), .Y_dir(w_yd),
        .X_pos(w_xp), .Y_pos(w_yp), .busyH(w_busy), .motion_doneH(w_done), .step_errH(w_err)
    );

    always #5 pulse_clk = ~pulse_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge pulse_clk);
        #1;
    endtask

    // model: every accepted request becomes a scheduled move with its own start and step-high cycle
    typedef struct {int start; int hs; bit d;} mv_t;
    mv_t mv[2][256];
    int nmv[2], last_end[2], cyc;
    bit last_dir[2], e_step[2], e_dir[2], e_busy, e_done, e_err, armed;
    logic [15:0] m_pos[2];

    task automatic req(input int a, input logic ac, input logic de);
        int n, s;
        if (!(ac || de)) return;
        if (ac && de) begin
            e_err = 1'b1;
            return;
        end
        n = cyc;
        if (n >= last_end[a]) s = n + 1;
        else if (nmv[a] > 0 && mv[a][nmv[a]-1].start > n + 1) begin
            e_err = 1'b1;
            return;
        end
        else s = (last_end[a] > n + 2) ? last_end[a] : n + 2;
        if (nmv[a] >= 256) return;
        mv[a][nmv[a]].start = s;
        mv[a][nmv[a]].d     = de;
        mv[a][nmv[a]].hs    = s + ((de != last_dir[a]) ? DS : 0);
        last_end[a] = mv[a][nmv[a]].hs + HI + LO;
        last_dir[a] = de;
        nmv[a]++;
    endtask

    initial forever begin
        @(posedge pulse_clk);
        if (!sys_rst_l) begin
            for (int a = 0; a < 2; a++) begin
                nmv[a] = 0; last_end[a] = 0; last_dir[a] = 0; m_pos[a] = 0; e_step[a] = 0; e_dir[a] = 0;
            end
            e_busy = 0; e_done = 0; e_err = 0; armed = 0; cyc = 0;
        end else begin
            req(0, X_acc, X_dec);
            req(1, Y_acc, Y_dec);
            armed = draw_overH || (armed && e_busy);
            for (int a = 0; a < 2; a++) begin
                logic [15:0] nxt;
                nxt = m_pos[a];
                for (int i = 0; i < nmv[a]; i++)
                    if (mv[a][i].hs == cyc + 1) nxt = mv[a][i].d ? nxt - 16'd1 : nxt + 16'd1;
                m_pos[a] = pos_clr ? 16'd0 : nxt;
            end
            cyc++;
            for (int a = 0; a < 2; a++) begin
                e_step[a] = 0;
                e_dir[a]  = 0;
                for (int i = 0; i < nmv[a]; i++) begin
                    if (mv[a][i].start <= cyc) e_dir[a] = mv[a][i].d;
                    if (mv[a][i].hs <= cyc && cyc < mv[a][i].hs + HI) e_step[a] = 1;
                end
            end
            e_busy = cyc < last_end[0] || cyc < last_end[1];
            e_done = armed && !e_busy;
        end
    end

    initial forever begin
        @(negedge pulse_clk);
        if (sys_rst_l) begin
            chk("x_step", X_step, e_step[0]);
            chk("x_dir", X_dir, e_dir[0]);
            chk("y_step", Y_step, e_step[1]);
            chk("y_dir", Y_dir, e_dir[1]);
            chk("x_pos", X_pos, m_pos[0]);
            chk("y_pos", Y_pos, m_pos[1]);
            chk("busy", busyH, e_busy);
            chk("done", motion_doneH, e_done);
            chk("err", step_errH, e_err);
            if (motion_doneH) done_seen++;
        end
    end

    initial begin
        repeat (3) @(posedge pulse_clk);
        #1 sys_rst_l = 1'b1;
        chk("rst_x_pos", X_pos, 16'd0);
        chk("rst_busy", busyH, 1'b0);
        chk("rst_outs", {X_step, X_dir, Y_step, Y_dir, motion_doneH, step_errH}, 6'd0);
        repeat (10) next();
        X_acc = 1'b1; next(); X_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pulse_clk);
            chk("p1_x_step", X_step, i < 2);
            chk("p1_busy", busyH, i < 4);
            next();
        end
        chk("p1_x_pos", X_pos, 16'd1);
        chk("p1_x_dir", X_dir, 1'b0);
        next();
        X_dec = 1'b1; next(); X_dec = 1'b0;
        @(negedge pulse_clk);
        chk("p2_dir", X_dir, 1'b1);
        chk("p2_setup_low", X_step, 1'b0);
        next();
        @(negedge pulse_clk);
        chk("p2_step", X_step, 1'b1);
        repeat (6) next();
        chk("p2_pos", X_pos, 16'd0);
        for (int i = 0; i < 3; i++) begin
            X_dec = 1'b1; next(); X_dec = 1'b0; next();
        end
        repeat (12) next();
        chk("p3_pos", X_pos, 16'hFFFD);
        chk("p3_no_err", step_errH, 1'b0);
        X_acc = 1'b1; X_dec = 1'b1; next(); X_acc = 1'b0; X_dec = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pulse_clk);
            chk("p4_no_step", X_step, 1'b0);
            next();
        end
        chk("p4_err", step_errH, 1'b1);
        chk("p4_pos", X_pos, 16'hFFFD);
        Y_acc = 1'b1; next(); Y_acc = 1'b0;
        @(negedge pulse_clk);
        chk("rst_pre_y_step", Y_step, 1'b1);
        #2 sys_rst_l = 1'b0;
        #1;
        chk("rst_mid_y_step", Y_step, 1'b0);
        chk("rst_mid_pos", {X_pos, Y_pos}, 32'd0);
        chk("rst_mid_err", step_errH, 1'b0);
        chk("rst_mid_busy", busyH, 1'b0);
        repeat (2) next();
        sys_rst_l = 1'b1;
        repeat (2) next();
        for (int i = 0; i < 3; i++) begin
            X_acc = 1'b1; next(); X_acc = 1'b0; next();
        end
        repeat (12) next();
        chk("p5_pos", X_pos, 16'd3);
        chk("p5_no_err", step_errH, 1'b0);
        X_acc = 1'b1; repeat (3) next(); X_acc = 1'b0;
        repeat (12) next();
        chk("p5_ovf_pos", X_pos, 16'd5);
        chk("p5_ovf_err", step_errH, 1'b1);
        pos_clr = 1'b1; next(); pos_clr = 1'b0;
        chk("p6_clr", {X_pos, Y_pos}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            X_acc = (i != 1);
            Y_dec = (i == 1 || i == 3);
            draw_overH = (i == 3);
            next();
            X_acc = 1'b0; Y_dec = 1'b0; draw_overH = 1'b0;
            repeat (2) next();
        end
        repeat (20) next();
        chk("p6_x_pos", X_pos, 16'd3);
        chk("p6_y_pos", Y_pos, 16'hFFFE);
        chk("p6_one_done", done_seen, 1);
        draw_overH = 1'b1; next(); draw_overH = 1'b0;
        @(negedge pulse_clk);
        chk("p7_done", motion_doneH, 1'b1);
        next();
        @(negedge pulse_clk);
        chk("p7_done_once", motion_doneH, 1'b0);
        next();
        X_acc = 1'b1; pos_clr = 1'b1; next(); X_acc = 1'b0; pos_clr = 1'b0;
        @(negedge pulse_clk);
        chk("p8_step", X_step, 1'b1);
        chk("p8_clr_pos", {X_pos, Y_pos}, 32'd0);
        repeat (6) next();
        for (int i = 0; i < 7; i++) begin
            w_acc = 1'b1; next(); w_acc = 1'b0; repeat (5) next();
        end
        chk("wrap_max", w_xp, 4'h7);
        w_acc = 1'b1; next(); w_acc = 1'b0; repeat (5) next();
        chk("wrap_min", w_xp, 4'h8);
        for (int i = 0; i < 8; i++) begin
            w_acc = 1'b1; next(); w_acc = 1'b0; repeat (5) next();
        end
        chk("wrap_zero", w_xp, 4'h0);
        chk("wrap_no_err", w_err, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
